snake_body: RTL and testbench
=============================

SNAKE_BODY -- requirements
Module: snake_body

Interface
REQ-001 Parameter MAX_LEN, 16, number of segment slots (4..32).
REQ-002 Parameter GRID_W, 30, playfield width in 8-pixel cells.
REQ-003 Parameter GRID_H, 30, playfield height in 8-pixel cells.
REQ-004 clk  in  1  system clock; the single clock domain.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle pulse: load initial snake and enter RUN.
REQ-007 step_tick  in  1  one-cycle pulse: advance the snake one cell.
REQ-008 dir_in  in  2  requested direction: 0 right, 1 left, 2 down, 3 up.
REQ-009 grow  in  1  one-cycle pulse: lengthen by one on the next step.
REQ-010 query_x, query_y  in  5 each  cell coordinate from the renderer.
REQ-011 query_hit, query_head  out  1 each  registered hit flags for the queried cell.
REQ-012 head_x, head_y  out  5 each  current head cell.
REQ-013 length  out  6  current segment count.
REQ-014 busy  out  1  high while in CHECK.
REQ-015 died  out  1  high while in DEAD.

Function
REQ-016 FSM states: IDLE, RUN, CHECK, DEAD.
REQ-017 start in IDLE or DEAD: load initial snake (head (12,15), body (11,15) (10,15) (9,15) (8,15)), length 5, direction right, grow_pending 0, next state RUN.
REQ-018 start in RUN or CHECK is ignored; start and step_tick in the same IDLE cycle: start wins, step ignored.
REQ-019 step_tick in RUN: latch dir_in unless it is the exact reverse of the current direction, in which case the current direction is kept.
REQ-020 Next head = head +/-1 in x or y per the latched direction; 5-bit unsigned arithmetic.
REQ-021 Next head outside 0..GRID_W-1 / 0..GRID_H-1: go to DEAD, segment array unchanged.
REQ-022 Otherwise, same cycle: seg[i] <= seg[i-1] for i>=1, seg[0] <= next head; if grow_pending and length<MAX_LEN, length increments and grow_pending clears; next state CHECK.
REQ-023 grow in RUN or CHECK sets grow_pending; repeated grows before a step collapse to one; grow at length==MAX_LEN is discarded at the step.
REQ-024 CHECK scans one segment per cycle, i = 1..length-1; seg[i]==seg[0] goes to DEAD immediately, scan end goes to RUN; CHECK lasts at most length-1 cycles.
REQ-025 step_tick during CHECK, IDLE or DEAD is dropped.
REQ-026 Query: query_hit = any i<length with seg[i]==(query_x,query_y); query_head = match on seg[0]; both registered, 1-cycle latency, valid in all states, 0 in IDLE.
REQ-027 Slots at index >= length never produce a hit or a collision.

Reset
REQ-028 reset_n low: state IDLE, segments loaded with the initial snake of REQ-017, length 5, direction right, grow_pending 0, query_hit 0, query_head 0, busy 0, died 0.
REQ-029 Reset asserted mid-CHECK aborts the scan with no DEAD transition.

Configuration
REQ-030 Macro SNAKE_WRAP_EN defined: an out-of-range next head wraps (GRID_W-1 <-> 0, GRID_H-1 <-> 0) and REQ-021 does not apply; undefined: wall exit is death per REQ-021.

Structure
REQ-031 Package snake_pkg holds the direction encoding, default grid size, initial head coordinates, initial length, and the state enumeration.
REQ-032 Sub-module snake_self_check holds the CHECK scan counter and comparator (start/done/hit handshake); segment storage stays in snake_body.

Verification
REQ-033 Reset, start, 3 steps with dir_in=0 -> head (15,15), length 5, died 0, busy high 4 cycles after each step.
REQ-034 Moving right, dir_in=1 then step -> reversal rejected, head x+1; dir_in=2 then step -> head y+1.
REQ-035 Head (29,y) moving right, step -> wrap undefined: died=1; SNAKE_WRAP_EN: head (0,y), died 0.
REQ-036 grow twice then step -> length 6; 12 grow+step pairs -> length saturates at 16.
REQ-037 Length 8, steps down/left/up into own body -> DEAD during CHECK, died=1; start -> initial snake, RUN.
REQ-038 query (10,15) after start -> query_hit=1, query_head=0 one cycle later; query (12,15) -> both 1; query (0,0) -> both 0.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake body datapath: direction and FSM
// encodings, default playfield size and the initial snake placement.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_UP    = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_CHECK,
    ST_DEAD
  } state_e;

  localparam int unsigned DEF_MAX_LEN = 16;
  localparam int unsigned DEF_GRID_W  = 30;
  localparam int unsigned DEF_GRID_H  = 30;
  localparam logic [4:0]  INIT_HEAD_X = 5'd12;
  localparam logic [4:0]  INIT_HEAD_Y = 5'd15;
  localparam int unsigned INIT_LEN    = 5;

  // Right/left and down/up differ only in bit 0.
  function automatic dir_e reverse_dir(dir_e d);
    return dir_e'(d ^ 2'b01);
  endfunction

  // Initial snake lies horizontally, tail extending left from the head.
  function automatic logic [4:0] init_seg_x(int unsigned i);
    return (i < INIT_LEN) ? INIT_HEAD_X - 5'(i) : '0;
  endfunction

  function automatic logic [4:0] init_seg_y(int unsigned i);
    return (i < INIT_LEN) ? INIT_HEAD_Y : '0;
  endfunction

endpackage

// File: rtl/snake_body_if.sv
// Control, query and status signals of snake_body; the game controller and
// renderer sit on the master side, the snake body on the slave side.
interface snake_body_if;
  logic       start;
  logic       step_tick;
  logic [1:0] dir_in;
  logic       grow;
  logic [4:0] query_x;
  logic [4:0] query_y;
  logic       query_hit;
  logic       query_head;
  logic [4:0] head_x;
  logic [4:0] head_y;
  logic [5:0] length;
  logic       busy;
  logic       died;

  modport master (
    output start, step_tick, dir_in, grow, query_x, query_y,
    input  query_hit, query_head, head_x, head_y, length, busy, died
  );

  modport slave (
    input  start, step_tick, dir_in, grow, query_x, query_y,
    output query_hit, query_head, head_x, head_y, length, busy, died
  );
endinterface

// File: rtl/snake_self_check.sv
// Self-collision scanner: after a move, compares one body segment per cycle
// (index 1..length-1) against the new head.
module snake_self_check #(
  parameter int unsigned MAX_LEN = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       active,
  input  logic [5:0] length,
  input  logic [4:0] seg_x [MAX_LEN],
  input  logic [4:0] seg_y [MAX_LEN],
  output logic       done,
  output logic       hit
);

  localparam int unsigned IDX_W = $clog2(MAX_LEN);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [4:0]       sel_x, sel_y;

  always_comb begin
    idx_d = idx_q;
    if (start) begin
      idx_d = IDX_W'(1);
    end else if (active) begin
      idx_d = idx_q + IDX_W'(1);
    end
  end

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_x = seg_x[i];
        sel_y = seg_y[i];
      end
    end
  end

  assign hit  = active && (6'(idx_q) < length) &&
                (sel_x == seg_x[0]) && (sel_y == seg_y[0]);
  assign done = active && (6'(idx_q) >= length - 6'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/snake_body.sv
// Snake segment store, movement FSM and renderer hit query.
// Define SNAKE_WRAP_EN to make the head wrap at the playfield edges instead of dying.
module snake_body
  import snake_pkg::*;
#(
  parameter int unsigned MAX_LEN = DEF_MAX_LEN,
  parameter int unsigned GRID_W  = DEF_GRID_W,
  parameter int unsigned GRID_H  = DEF_GRID_H
) (
  input  logic         clk,
  input  logic         reset_n,
  snake_body_if.slave  bus
);

  state_e     state_q, state_d;
  dir_e       dir_q, dir_d, step_dir;
  logic       grow_pend_q, grow_pend_d;
  logic [5:0] length_q, length_d;
  logic [4:0] seg_x_q [MAX_LEN];
  logic [4:0] seg_y_q [MAX_LEN];
  logic [4:0] seg_x_d [MAX_LEN];
  logic [4:0] seg_y_d [MAX_LEN];
  logic       query_hit_q, query_hit_d;
  logic       query_head_q, query_head_d;
  logic [4:0] nx, ny;
  logic       wall_hit;
  logic       chk_start, chk_done, chk_hit, in_check;

  assign in_check = (state_q == ST_CHECK);

  snake_self_check #(.MAX_LEN(MAX_LEN)) u_self_check (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (chk_start),
    .active  (in_check),
    .length  (length_q),
    .seg_x   (seg_x_q),
    .seg_y   (seg_y_q),
    .done    (chk_done),
    .hit     (chk_hit)
  );

  // Next head cell from the direction that this step would latch.
  always_comb begin
    step_dir = (dir_e'(bus.dir_in) == reverse_dir(dir_q)) ? dir_q : dir_e'(bus.dir_in);
    nx       = seg_x_q[0];
    ny       = seg_y_q[0];
    wall_hit = 1'b0;
`ifdef SNAKE_WRAP_EN
    case (step_dir)
      DIR_RIGHT: nx = (32'(seg_x_q[0]) == GRID_W - 1) ? '0 : seg_x_q[0] + 5'd1;
      DIR_LEFT:  nx = (seg_x_q[0] == '0) ? 5'(GRID_W - 1) : seg_x_q[0] - 5'd1;
      DIR_DOWN:  ny = (32'(seg_y_q[0]) == GRID_H - 1) ? '0 : seg_y_q[0] + 5'd1;
      default:   ny = (seg_y_q[0] == '0) ? 5'(GRID_H - 1) : seg_y_q[0] - 5'd1;
    endcase
`else
    case (step_dir)
      DIR_RIGHT: nx = seg_x_q[0] + 5'd1;
      DIR_LEFT:  nx = seg_x_q[0] - 5'd1;
      DIR_DOWN:  ny = seg_y_q[0] + 5'd1;
      default:   ny = seg_y_q[0] - 5'd1;
    endcase
    // Moving off the low edge underflows to 31, so one upper bound covers both walls.
    wall_hit = (32'(nx) >= GRID_W) || (32'(ny) >= GRID_H);
`endif
  end

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    grow_pend_d = grow_pend_q;
    length_d    = length_q;
    seg_x_d     = seg_x_q;
    seg_y_d     = seg_y_q;
    chk_start   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DEAD: begin
        if (bus.start) begin
          for (int unsigned i = 0; i < MAX_LEN; i++) begin
            seg_x_d[i] = init_seg_x(i);
            seg_y_d[i] = init_seg_y(i);
          end
          length_d    = 6'(INIT_LEN);
          dir_d       = DIR_RIGHT;
          grow_pend_d = 1'b0;
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.grow) begin
          grow_pend_d = 1'b1;
        end
        if (bus.step_tick) begin
          dir_d = step_dir;
          if (wall_hit) begin
            state_d = ST_DEAD;
          end else begin
            for (int unsigned i = 1; i < MAX_LEN; i++) begin
              seg_x_d[i] = seg_x_q[i-1];
              seg_y_d[i] = seg_y_q[i-1];
            end
            seg_x_d[0] = nx;
            seg_y_d[0] = ny;
            // Pending grow is consumed even when saturated; a same-cycle grow re-arms it.
            if (grow_pend_q) begin
              grow_pend_d = bus.grow;
              if (length_q < 6'(MAX_LEN)) begin
                length_d = length_q + 6'd1;
              end
            end
            chk_start = 1'b1;
            state_d   = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (bus.grow) begin
          grow_pend_d = 1'b1;
        end
        if (chk_hit) begin
          state_d = ST_DEAD;
        end else if (chk_done) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    query_hit_d  = 1'b0;
    query_head_d = 1'b0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if ((6'(i) < length_q) && (seg_x_q[i] == bus.query_x) && (seg_y_q[i] == bus.query_y)) begin
        query_hit_d = 1'b1;
      end
    end
    query_head_d = (seg_x_q[0] == bus.query_x) && (seg_y_q[0] == bus.query_y);
    if (state_q == ST_IDLE) begin
      query_hit_d  = 1'b0;
      query_head_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      dir_q        <= DIR_RIGHT;
      grow_pend_q  <= 1'b0;
      length_q     <= 6'(INIT_LEN);
      query_hit_q  <= 1'b0;
      query_head_q <= 1'b0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= init_seg_x(i);
        seg_y_q[i] <= init_seg_y(i);
      end
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      grow_pend_q  <= grow_pend_d;
      length_q     <= length_d;
      query_hit_q  <= query_hit_d;
      query_head_q <= query_head_d;
      seg_x_q      <= seg_x_d;
      seg_y_q      <= seg_y_d;
    end
  end

  assign bus.head_x     = seg_x_q[0];
  assign bus.head_y     = seg_y_q[0];
  assign bus.length     = length_q;
  assign bus.busy       = in_check;
  assign bus.died       = (state_q == ST_DEAD);
  assign bus.query_hit  = query_hit_q;
  assign bus.query_head = query_head_q;

endmodule

// File: tb/tb_snake_body.sv
// Bench for snake_body: directed sequences and a query table, then random
// play checked against a queue-based model of the snake.
module tb_snake_body;

  localparam int MAXL   = 16;
  localparam int GW     = 30;
  localparam int GH     = 30;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DEAD = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  snake_body_if bus();

  snake_body #(.MAX_LEN(MAXL), .GRID_W(GW), .GRID_H(GH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: queue of cells, index 0 = head.
  int qx[$];
  int qy[$];
  int m_st;
  int m_dir;
  bit m_pend;

  typedef struct {
    int x;
    int y;
    int e_hit;
    int e_head;
  } qvec_t;

  qvec_t qtab[6];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rev(input int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  task automatic model_init(input int st);
    qx.delete();
    qy.delete();
    for (int i = 0; i < 5; i++) begin
      qx.push_back(12 - i);
      qy.push_back(15);
    end
    m_st = st;
    m_dir = 0;
    m_pend = 0;
  endtask

  function automatic int m_hit(input int x, input int y);
    if (m_st == M_IDLE) return 0;
    foreach (qx[i]) if (qx[i] == x && qy[i] == y) return 1;
    return 0;
  endfunction

  function automatic int m_head(input int x, input int y);
    if (m_st == M_IDLE) return 0;
    return (qx[0] == x && qy[0] == y) ? 1 : 0;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".head_x"}, int'(bus.head_x), qx[0]);
    chk({tag, ".head_y"}, int'(bus.head_y), qy[0]);
    chk({tag, ".length"}, int'(bus.length), qx.size());
    chk({tag, ".died"}, int'(bus.died), (m_st == M_DEAD) ? 1 : 0);
    chk({tag, ".busy"}, int'(bus.busy), 0);
  endtask

  task automatic apply_reset;
    bus.start = 0;
    bus.step_tick = 0;
    bus.grow = 0;
    bus.dir_in = 0;
    reset_n = 0;
    #7;
    model_init(M_IDLE);
    check_state("reset");
    chk("reset.query_hit", int'(bus.query_hit), 0);
    chk("reset.query_head", int'(bus.query_head), 0);
    @(negedge clk);
    reset_n = 1;
    tick;
  endtask

  task automatic do_start;
    bus.start = 1;
    tick;
    bus.start = 0;
    if (m_st != M_RUN) model_init(M_RUN);
    check_state("start");
  endtask

  task automatic do_grow;
    bus.grow = 1;
    tick;
    bus.grow = 0;
    if (m_st == M_RUN) m_pend = 1;
  endtask

  task automatic do_query(input int x, input int y, input int eh, input int ehd, input string name);
    bus.query_x = 5'(x);
    bus.query_y = 5'(y);
    tick;
    chk({name, ".query_hit"}, int'(bus.query_hit), eh);
    chk({name, ".query_head"}, int'(bus.query_head), ehd);
  endtask

  // One step; optionally pulse step_tick and/or grow during the first busy cycle.
  task automatic do_step(input int d, input bit inj_step, input bit inj_grow);
    int nx, ny, nd, len, exp_busy, cnt;
    bit wall, coll;
    exp_busy = 0;
    if (m_st == M_RUN) begin
      nd = (d == rev(m_dir)) ? m_dir : d;
      m_dir = nd;
      nx = qx[0];
      ny = qy[0];
      case (nd)
        0: nx++;
        1: nx--;
        2: ny++;
        default: ny--;
      endcase
      wall = (nx < 0) || (nx >= GW) || (ny < 0) || (ny >= GH);
`ifdef SNAKE_WRAP_EN
      nx = (nx + GW) % GW;
      ny = (ny + GH) % GH;
      wall = 0;
`endif
      if (wall) begin
        m_st = M_DEAD;
      end else begin
        len = qx.size();
        qx.push_front(nx);
        qy.push_front(ny);
        if (m_pend && len < MAXL) len++;
        m_pend = 0;
        while (qx.size() > len) begin
          void'(qx.pop_back());
          void'(qy.pop_back());
        end
        coll = 0;
        exp_busy = len - 1;
        for (int i = 1; i < len; i++) begin
          if (!coll && qx[i] == nx && qy[i] == ny) begin
            coll = 1;
            exp_busy = i;
          end
        end
        m_st = coll ? M_DEAD : M_RUN;
        if (inj_grow) m_pend = 1;
      end
    end
    bus.dir_in = 2'(d);
    bus.step_tick = 1;
    tick;
    bus.step_tick = 0;
    cnt = 0;
    while (bus.busy && cnt < 64) begin
      if (cnt == 0) begin
        bus.step_tick = inj_step;
        bus.grow = inj_grow;
        bus.dir_in = 2'(rev(m_dir) ^ 1);
      end
      tick;
      bus.step_tick = 0;
      bus.grow = 0;
      cnt++;
    end
    chk("step.busy_cycles", cnt, exp_busy);
    check_state("step");
  endtask

  initial begin
    int r, x, y, k;
    bus.start = 0;
    bus.step_tick = 0;
    bus.grow = 0;
    bus.dir_in = 0;
    bus.query_x = 0;
    bus.query_y = 0;

    qtab[0] = '{x: 10, y: 15, e_hit: 1, e_head: 0};
    qtab[1] = '{x: 12, y: 15, e_hit: 1, e_head: 1};
    qtab[2] = '{x: 0,  y: 0,  e_hit: 0, e_head: 0};
    qtab[3] = '{x: 8,  y: 15, e_hit: 1, e_head: 0};
    qtab[4] = '{x: 7,  y: 15, e_hit: 0, e_head: 0};
    qtab[5] = '{x: 12, y: 16, e_hit: 0, e_head: 0};

    // Reset state, IDLE behaviour
    apply_reset();
    do_query(12, 15, 0, 0, "idle");
    do_step(0, 0, 0);

    // Initial snake placement via query table
    do_start();
    for (int i = 0; i < 6; i++) begin
      do_query(qtab[i].x, qtab[i].y, qtab[i].e_hit, qtab[i].e_head, $sformatf("qtab%0d", i));
    end

    // Three steps right
    for (int i = 0; i < 3; i++) do_step(0, 0, 0);
    chk("three_steps.head_x", int'(bus.head_x), 15);
    chk("three_steps.length", int'(bus.length), 5);

    // Reversal rejected, then turn down
    do_step(1, 0, 0);
    chk("reverse.head_x", int'(bus.head_x), 16);
    do_step(2, 0, 0);
    chk("turn_down.head_y", int'(bus.head_y), 16);

    // Step and grow during CHECK: step dropped, grow remembered
    do_step(0, 1, 1);
    do_step(0, 0, 0);
    chk("grow_in_check.length", int'(bus.length), 6);

    // start while running is ignored
    do_start();

    // Drive into the right wall
    for (int i = 0; i < 40 && bus.head_x != 5'd29 && m_st == M_RUN; i++) do_step(0, 0, 0);
    chk("wall.at_edge", int'(bus.head_x), 29);
    do_step(0, 0, 0);
`ifdef SNAKE_WRAP_EN
    chk("wall.wrap_head_x", int'(bus.head_x), 0);
    chk("wall.wrap_died", int'(bus.died), 0);
`else
    chk("wall.died", int'(bus.died), 1);
    chk("wall.head_kept", int'(bus.head_x), 29);
    do_step(0, 0, 0);
`endif

    // Growth and saturation
    apply_reset();
    do_start();
    do_grow();
    do_grow();
    do_step(0, 0, 0);
    chk("grow.length6", int'(bus.length), 6);
    for (int i = 0; i < 12; i++) begin
      do_grow();
      do_step(0, 0, 0);
    end
    chk("grow.saturated", int'(bus.length), 16);

    // Self collision at length 8
    apply_reset();
    do_start();
    for (int i = 0; i < 3; i++) begin
      do_grow();
      do_step(0, 0, 0);
    end
    chk("self.length8", int'(bus.length), 8);
    do_step(2, 0, 0);
    do_step(1, 0, 0);
    do_step(3, 0, 0);
    chk("self.died", int'(bus.died), 1);
    do_query(14, 15, m_hit(14, 15), m_head(14, 15), "dead_query");
    do_start();
    chk("restart.head_x", int'(bus.head_x), 12);
    do_step(0, 0, 0);

    // Reset in the middle of CHECK
    bus.dir_in = 0;
    bus.step_tick = 1;
    tick;
    bus.step_tick = 0;
    chk("midchk.busy", int'(bus.busy), 1);
    #2;
    reset_n = 0;
    #1;
    model_init(M_IDLE);
    check_state("midchk_reset");
    @(negedge clk);
    reset_n = 1;
    repeat (6) tick;
    check_state("midchk_after");

    // start and step_tick in the same IDLE cycle
    bus.start = 1;
    bus.step_tick = 1;
    bus.dir_in = 2;
    tick;
    bus.start = 0;
    bus.step_tick = 0;
    model_init(M_RUN);
    check_state("start_step");
    do_step(0, 0, 0);
    chk("start_step.next_head_x", int'(bus.head_x), 13);

    // Random play against the model
    for (int n = 0; n < 400; n++) begin
      if (m_st != M_RUN) begin
        do_start();
      end else begin
        r = $urandom_range(0, 9);
        if (r < 5) begin
          do_step($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
        end else if (r < 7) begin
          do_grow();
        end else begin
          if ($urandom_range(0, 1) == 1) begin
            k = $urandom_range(0, qx.size() - 1);
            x = qx[k];
            y = qy[k];
          end else begin
            x = $urandom_range(0, 31);
            y = $urandom_range(0, 31);
          end
          do_query(x, y, m_hit(x, y), m_head(x, y), "rand");
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
